// File: rtl/bcd_digit_display_counter.sv
// bcd_digit_display_counter
//   Counts debounced rising edges of an asynchronous, possibly bouncy input
//   and shows the count (BCD 0-9, wrapping 9->0) on the rightmost digit of a
//   4-digit multiplexed seven-segment display.
//
// Ports:
//   clk                  : system clock, all state updates on rising edge
//   reset                : asynchronous reset, active low
//   pulse                : asynchronous count request (one count per debounced 0->1)
//   seven_segment_data   : active-low segments, bit order {dp,g,f,e,d,c,b,a}
//   seven_segment_enable : active-low digit enables, bit 0 = rightmost digit
//
// Parameters:
//   DEBOUNCE_CYCLES      : consecutive synchronised cycles the input must differ
//                          from the debounced level before that level changes
module bcd_digit_display_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse,
    output logic [7:0] seven_segment_data,
    output logic [3:0] seven_segment_enable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic [3:0]       digit;
    logic             stable_rise;

    // True on exactly the edge where the debounced level is about to flip 0->1,
    // so the digit advances on the same edge that 'stable' rises.
    assign stable_rise = (sync2 != stable) && (db_cnt == CNT_LAST) && sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
            digit  <= '0;
        end else begin
            sync1 <= pulse;
            sync2 <= sync1;

            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (stable_rise) begin
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
        end
    end

    always_comb begin
        seven_segment_data = 8'hFF;
        case (digit)
            4'd0:    seven_segment_data = 8'hC0;
            4'd1:    seven_segment_data = 8'hF9;
            4'd2:    seven_segment_data = 8'hA4;
            4'd3:    seven_segment_data = 8'hB0;
            4'd4:    seven_segment_data = 8'h99;
            4'd5:    seven_segment_data = 8'h92;
            4'd6:    seven_segment_data = 8'h82;
            4'd7:    seven_segment_data = 8'hF8;
            4'd8:    seven_segment_data = 8'h80;
            4'd9:    seven_segment_data = 8'h90;
            default: seven_segment_data = 8'hFF;
        endcase
    end

    assign seven_segment_enable = 4'b1110;

endmodule

// File: tb/tb_bcd_digit_display_counter.sv
// tb_bcd_digit_display_counter
//   Directed checks of the BCD display counter: reset, held input, full
//   count sequence with wrap, glitch/bounce rejection, asynchronous reset
//   mid-count, and the DEBOUNCE_CYCLES=1 corner on a second instance.
module tb_bcd_digit_display_counter;

    logic       clk;
    logic       reset;
    logic       pulse;
    logic [7:0] data;
    logic [3:0] enable;

    logic       reset1;
    logic       pulse1;
    logic [7:0] data1;
    logic [3:0] enable1;

    int unsigned n_asserts;
    int unsigned n_fails;

    bcd_digit_display_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pulse                (pulse),
        .seven_segment_data   (data),
        .seven_segment_enable (enable)
    );

    bcd_digit_display_counter #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk                  (clk),
        .reset                (reset1),
        .pulse                (pulse1),
        .seven_segment_data   (data1),
        .seven_segment_enable (enable1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic edges(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic clean_pulse();
        pulse = 1'b1;
        edges(10);
        pulse = 1'b0;
        edges(10);
    endtask

    logic [7:0] seq [10];

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        seq = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90, 8'hC0};

        reset  = 1'b0;
        pulse  = 1'b0;
        reset1 = 1'b0;
        pulse1 = 1'b0;

        // reset hold: sampled every 10 ns up to 120 ns
        for (int unsigned i = 0; i < 12; i++) begin
            #10;
            check("reset_data", data, 8'hC0);
            check("reset_enable", {4'h0, enable}, 8'h0E);
        end

        // t=120 (falling edge): release reset with pulse high
        reset  = 1'b1;
        reset1 = 1'b1;
        pulse  = 1'b1;
        for (int unsigned k = 1; k <= 6; k++) begin
            edges(1);
            check($sformatf("held_edge%0d", k), data, (k < 6) ? 8'hC0 : 8'hF9);
        end
        edges(100);
        check("held_1us", data, 8'hF9);
        pulse = 1'b0;
        edges(10);
        check("held_release", data, 8'hF9);

        // back to zero, then ten clean pulses
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rezero", data, 8'hC0);
        @(negedge clk);
        reset = 1'b1;
        edges(2);
        for (int unsigned p = 0; p < 10; p++) begin
            clean_pulse();
            check($sformatf("seq_pulse%0d", p + 1), data, seq[p]);
        end

        // glitch of DEBOUNCE_CYCLES-1 cycles: no change
        pulse = 1'b1;
        edges(3);
        pulse = 1'b0;
        edges(20);
        check("glitch", data, 8'hC0);

        // bounce then steady high: exactly one increment
        pulse = 1'b1; edges(1);
        pulse = 1'b0; edges(1);
        pulse = 1'b1; edges(2);
        pulse = 1'b0; edges(1);
        pulse = 1'b1; edges(1);
        pulse = 1'b0; edges(2);
        check("bounce_mid", data, 8'hC0);
        pulse = 1'b1;
        edges(20);
        check("bounce_high", data, 8'hF9);
        pulse = 1'b0;
        edges(20);
        check("bounce_low", data, 8'hF9);

        // advance to 7
        for (int unsigned p = 0; p < 6; p++) begin
            clean_pulse();
        end
        check("at_seven", data, 8'hF8);

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", data, 8'hC0);
        check("async_reset_en", {4'h0, enable}, 8'h0E);
        pulse = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        edges(20);
        check("post_reset_inc", data, 8'hF9);
        pulse = 1'b0;

        // DEBOUNCE_CYCLES=1: 2-cycle pulse counts at the 3rd sampling edge
        check("p1_idle", data1, 8'hC0);
        pulse1 = 1'b1;
        edges(1);
        check("p1_edge1", data1, 8'hC0);
        edges(1);
        pulse1 = 1'b0;
        check("p1_edge2", data1, 8'hC0);
        edges(1);
        check("p1_edge3", data1, 8'hF9);
        edges(10);
        check("p1_hold", data1, 8'hF9);
        check("p1_enable", {4'h0, enable1}, 8'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/bcd_digit_display_counter.md
Name: bcd_digit_display_counter

Overview:
- Single-digit decimal (BCD 0-9) event counter driving one digit of a 4-digit multiplexed seven-segment display.
- `pulse` is an asynchronous, possibly bouncy, level input that may stay high for many clock cycles.
  - It is synchronised and debounced.
  - Each debounced rising edge advances the digit by exactly one.
- The digit is decoded to active-low segment drive on display position 0 only.

Parameters:
- DEBOUNCE_CYCLES, default 4, number of consecutive cycles the synchronised `pulse` must differ from the debounced level before the debounced level changes. Legal range is 1 to 2^20.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pulse  input  1  asynchronous count request; one count per debounced 0->1 transition.
- seven_segment_data  output  8  active-low segment drive. Bit order {dp,g,f,e,d,c,b,a}.
- seven_segment_enable  output  4  active-low digit enables; bit 0 is the rightmost digit.

Behaviour:
- Registers:
  - Synchroniser: sync1, sync2.
  - Debounce: level `stable` and counter `db_cnt`, with width ceil(log2(DEBOUNCE_CYCLES))+1.
  - Digit: 4-bit BCD `digit`.
- Reset (reset==0, asynchronous, takes effect immediately):
  - sync1, sync2, stable, db_cnt and digit all go to 0.
  - Outputs during and after reset: seven_segment_data=8'hC0 (shows "0"), seven_segment_enable=4'b1110.
  - Reset released mid-count behaves exactly like power-up.
- Synchroniser: each edge, sync1<=pulse and sync2<=sync1.
- Debounce, evaluated each clock edge:
  - If sync2==stable: db_cnt<=0.
  - Else if db_cnt==DEBOUNCE_CYCLES-1: stable<=sync2 and db_cnt<=0.
  - Else: db_cnt<=db_cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes `stable`.
- Count:
  - On the edge where `stable` goes 0->1, digit<=digit+1. If digit==9 it wraps to 0 instead.
  - A 1->0 transition of `stable` does nothing.
  - Holding `pulse` high indefinitely yields exactly one increment.
- Latency: if `pulse` is first sampled high at edge N and stays high, `digit` changes at edge N+DEBOUNCE_CYCLES+1. With the default this is the 6th sampling edge.
- Digit values outside 0-9 are unreachable. If forced, the decoder outputs 8'hFF (blank).
- Decode is combinational from the registered `digit`, with dp always off (bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- seven_segment_enable is constant 4'b1110. Digits 1-3 are permanently off.
- Outputs change only as a result of `digit` changing or reset.

Test Plan:
- Reset hold: reset=0 for 125 ns with clk period 10 ns, pulse=0 -> seven_segment_data=8'hC0 and seven_segment_enable=4'b1110 throughout.
- Held pulse: release reset and set pulse=1 together, then hold for 1 us -> data becomes 8'hF9 exactly DEBOUNCE_CYCLES+2 sampling edges later and stays 8'hF9 (single increment).
- Sequence and wrap: apply 10 clean pulses, each 10 cycles high and 10 cycles low:
  - Data steps through F9,A4,B0,99,92,82,F8,80,90.
  - The 10th pulse gives C0 (wrap 9->0).
- Glitch rejection: pulse high for DEBOUNCE_CYCLES-1 cycles then low -> no change. Bouncy 0/1 toggling followed by a steady high -> exactly one increment.
- Async reset mid-operation: at digit 7 (F8), drive reset=0 between clock edges -> data=8'hC0 immediately, before the next clk edge. Release with pulse held high -> one increment to F9.
- Parameter corner: with DEBOUNCE_CYCLES=1, a 2-cycle-high pulse increments once, 3 edges after it is first sampled high.
